// File: rtl/load_read_unit_pkg.sv
// Shared definitions for the load read path: load-size encodings, FSM states,
// default memory latency and the alignment rule.
package load_read_unit_pkg;

  typedef enum logic [1:0] {
    LS_WORD = 2'b00,
    LS_HALF = 2'b01,
    LS_BYTE = 2'b10,
    LS_RSVD = 2'b11
  } load_size_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_ISSUE = 2'b01,
    ST_WAIT  = 2'b10,
    ST_DONE  = 2'b11
  } lru_state_e;

  localparam int unsigned DEFAULT_MEM_LATENCY = 1;

  // Reserved size behaves as a word, so it carries the word alignment rule.
  function automatic logic is_misaligned(input load_size_e size, input logic [1:0] offset);
    logic mis;
    case (size)
      LS_BYTE: mis = 1'b0;
      LS_HALF: mis = offset[0];
      default: mis = |offset;
    endcase
    return mis;
  endfunction

endpackage

// File: rtl/load_read_unit_if.sv
// Request, memory and result signals of the load read unit, bundled with
// modports for the unit (slave) and the requesting/memory side (master).
interface load_read_unit_if;
  logic        Start;
  logic [1:0]  LoadSize;
  logic        LoadSigned;
  logic [31:0] Address;
  logic [31:0] MemAddr;
  logic        MemRead;
  logic [31:0] MemData_in;
  logic [31:0] LoadData;
  logic        LoadDone;
  logic        Misaligned;
  logic        Busy;

  modport slave (
    input  Start, LoadSize, LoadSigned, Address, MemData_in,
    output MemAddr, MemRead, LoadData, LoadDone, Misaligned, Busy
  );

  modport master (
    output Start, LoadSize, LoadSigned, Address, MemData_in,
    input  MemAddr, MemRead, LoadData, LoadDone, Misaligned, Busy
  );
endinterface

// File: rtl/load_read_unit_extract_extend.sv
// Byte-lane extraction and sign/zero extension of a little-endian memory word;
// purely combinational so the store side can reuse the same lane mapping.
module load_extract_extend
  import load_read_unit_pkg::*;
(
  input  logic [31:0] word_i,
  input  logic [1:0]  offset_i,
  input  load_size_e  size_i,
  input  logic        signed_i,
  output logic [31:0] result_o
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;
  logic        byte_msb;
  logic        half_msb;

  always_comb begin
    case (offset_i)
      2'd0:    byte_sel = word_i[7:0];
      2'd1:    byte_sel = word_i[15:8];
      2'd2:    byte_sel = word_i[23:16];
      default: byte_sel = word_i[31:24];
    endcase
    half_sel = offset_i[1] ? word_i[31:16] : word_i[15:0];
    byte_msb = signed_i & byte_sel[7];
    half_msb = signed_i & half_sel[15];

    case (size_i)
      LS_BYTE: result_o = {{24{byte_msb}}, byte_sel};
      LS_HALF: result_o = {{16{half_msb}}, half_sel};
      default: result_o = word_i;
    endcase
  end

endmodule

// File: rtl/load_read_unit.sv
// Multicycle load front end: latches a request, issues one word-aligned read,
// waits out the memory latency, then registers the extended field as LoadData.
module load_read_unit
  import load_read_unit_pkg::*;
#(
  parameter int unsigned MEM_LATENCY = DEFAULT_MEM_LATENCY,
  parameter int unsigned CNT_W       = 4
) (
  input  logic             clk,
  input  logic             reset,
  load_read_unit_if.slave  bus
);

  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MEM_LATENCY - 1);

  lru_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [31:0]      addr_q, addr_d;
  load_size_e       size_q, size_d;
  logic             sgn_q, sgn_d;
  logic             mis_q, mis_d;
  logic [31:0]      load_data_q, load_data_d;
  logic [31:0]      extracted;
  logic             req_mis;

  load_extract_extend u_extract (
    .word_i   (bus.MemData_in),
    .offset_i (addr_q[1:0]),
    .size_i   (size_q),
    .signed_i (sgn_q),
    .result_o (extracted)
  );

  assign req_mis = is_misaligned(load_size_e'(bus.LoadSize), bus.Address[1:0]);

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    addr_d      = addr_q;
    size_d      = size_q;
    sgn_d       = sgn_q;
    mis_d       = mis_q;
    load_data_d = load_data_q;

    case (state_q)
      ST_IDLE: begin
        if (bus.Start) begin
          addr_d  = bus.Address;
          size_d  = load_size_e'(bus.LoadSize);
          sgn_d   = bus.LoadSigned;
          mis_d   = req_mis;
          // A faulting request skips the memory access entirely.
          state_d = req_mis ? ST_DONE : ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        cnt_d   = CNT_LOAD;
        state_d = ST_WAIT;
      end
      ST_WAIT: begin
        if (cnt_q == '0) begin
          load_data_d = extracted;
          state_d     = ST_DONE;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      addr_q      <= '0;
      size_q      <= LS_WORD;
      sgn_q       <= 1'b0;
      mis_q       <= 1'b0;
      load_data_q <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      addr_q      <= addr_d;
      size_q      <= size_d;
      sgn_q       <= sgn_d;
      mis_q       <= mis_d;
      load_data_q <= load_data_d;
    end
  end

  // Outputs decode straight from registered state so reset clears them at once.
  assign bus.MemRead    = (state_q == ST_ISSUE);
  assign bus.MemAddr    = {addr_q[31:2], 2'b00};
  assign bus.LoadData   = load_data_q;
  assign bus.LoadDone   = (state_q == ST_DONE);
  assign bus.Misaligned = (state_q == ST_DONE) & mis_q;
  assign bus.Busy       = (state_q != ST_IDLE);

endmodule
